// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response, branch
// redirect input and the decode-side valid/ready instruction stream.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  branch_taken, branch_target,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output branch_taken, branch_target,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches, queues in-order
// responses and presents instruction/PC pairs to decode; redirects flush and discard.
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{word: 32'h0, pc: RESET_PC_W};

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    entry_t        mem_q [DEPTH];

    logic          grant_c;
    logic          keep_c;
    logic          pop_c;
    logic [31:0]   target_c;
    logic [1:0]    unused_target_lo;

    // Credit check counts queued words plus every request still in flight,
    // so a kept response always finds a free slot.
    assign bus.imem_req  = !reset && ((SW'(count_q) + SW'(outstanding_q)) < SW'(DEPTH));
    assign bus.imem_addr = fetch_pc_q;

    assign grant_c          = bus.imem_req && bus.imem_gnt;
    assign keep_c           = bus.imem_rvalid && (discard_q == '0) && !bus.branch_taken;
    assign pop_c            = (count_q != '0) && bus.instr_ready;
    assign target_c         = {bus.branch_target[31:2], 2'b00};
    assign unused_target_lo = bus.branch_target[1:0];

    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = mem_q[head_q].word;
    assign bus.instr_pc    = mem_q[head_q].pc;

    // Next-state bookkeeping; a redirect overrides pop, write and issue updates.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        discard_d     = discard_q;
        head_d        = head_q;
        tail_d        = tail_q;
        outstanding_d = CW'(SW'(outstanding_q) + SW'(grant_c) - SW'(bus.imem_rvalid));

        if (bus.branch_taken) begin
            fetch_pc_d = target_c;
            resp_pc_d  = target_c;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            discard_d  = outstanding_d;
        end else begin
            if (grant_c) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (bus.imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (keep_c) begin
                tail_d    = tail_q + PW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop_c) begin
                head_d = head_q + PW'(1);
            end
            count_d = CW'(SW'(count_q) + SW'(keep_c) - SW'(pop_c));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC_W;
            resp_pc_q     <= RESET_PC_W;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            mem_q         <= '{default: RESET_ENTRY};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            if (keep_c) begin
                mem_q[tail_q] <= '{word: bus.imem_rdata, pc: resp_pc_q};
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order variable-latency memory model,
// accepted-instruction monitor, one task per scenario.
module tb_fetch_unit;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } acc_t;

    logic clk;
    logic reset;
    fetch_unit_if bus ();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    n_chk;
    int    n_pass;
    int    cyc;
    int    lat;
    bit    gnt_en;
    pend_t pend_q[$];
    acc_t  acc_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: grants when enabled, answers in order lat cycles after grant.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            pend_q.delete();
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
            bus.imem_gnt    = 1'b0;
        end else begin
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = pend_q[0].addr ^ KEY;
                void'(pend_q.pop_front());
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = 32'hDEAD_BEEF;
            end
            bus.imem_gnt = gnt_en;
            if (bus.imem_req && gnt_en) pend_q.push_back('{addr: bus.imem_addr, due: cyc + lat});
        end
    end

    // Records every instruction decode accepts.
    always @(negedge clk) begin
        if (!reset && bus.instr_valid && bus.instr_ready)
            acc_q.push_back('{pc: bus.instr_pc, data: bus.instr});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit rdy, input int l);
        reset = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.instr_ready   = rdy;
        gnt_en = 1'b1;
        lat    = l;
        step();
        step();
        reset = 1'b0;
        acc_q.delete();
    endtask

    task automatic wait_acc(input int n, input int budget, output bit ok);
        int i;
        i = 0;
        while (acc_q.size() < n && i < budget) begin
            step();
            i++;
        end
        ok = (acc_q.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.instr_ready   = 1'b1;
        gnt_en = 1'b1;
        lat    = 1;
        step();
        step();
        n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", bus.imem_req); else n_pass++;
        n_chk++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_addr: got %h exp 0", bus.imem_addr); else n_pass++;
        n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus.instr_valid); else n_pass++;
        n_chk++; if (bus.instr !== 32'h0) $display("FAIL rst_instr: got %h exp 0", bus.instr); else n_pass++;
        n_chk++; if (bus.instr_pc !== 32'h0) $display("FAIL rst_pc: got %h exp 0", bus.instr_pc); else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++; if (bus.imem_req !== 1'b1) $display("FAIL first_req: got %b exp 1", bus.imem_req); else n_pass++;
        n_chk++; if (bus.imem_addr !== 32'h0) $display("FAIL first_addr: got %h exp 0", bus.imem_addr); else n_pass++;
        step();
        n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL first_c1_valid: got %b exp 0", bus.instr_valid); else n_pass++;
        step();
        n_chk++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== KEY)
            $display("FAIL first_c2: got v=%b pc=%h d=%h exp v=1 pc=0 d=%h", bus.instr_valid, bus.instr_pc, bus.instr, KEY);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [31:0] pc;
        do_reset(1'b1, 1);
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            pc = 32'(4 * k);
            n_chk++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== pc || bus.instr !== (pc ^ KEY))
                $display("FAIL stream_%0d: got v=%b pc=%h d=%h exp v=1 pc=%h d=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, pc, pc ^ KEY);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] pc;
        do_reset(1'b0, 1);
        step();
        step();
        n_chk++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) $display("FAIL bp_first: got v=%b pc=%h exp v=1 pc=0", bus.instr_valid, bus.instr_pc); else n_pass++;
        repeat (5) step();
        n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL bp_full_req: got %b exp 0", bus.imem_req); else n_pass++;
        n_chk++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== KEY)
            $display("FAIL bp_hold: got v=%b pc=%h d=%h exp v=1 pc=0 d=%h", bus.instr_valid, bus.instr_pc, bus.instr, KEY);
        else n_pass++;
        bus.instr_ready = 1'b1;
        wait_acc(12, 40, ok);
        n_chk++; if (!ok) $display("FAIL bp_timeout: got %0d accepted exp 12", acc_q.size()); else n_pass++;
        for (int i = 0; i < acc_q.size() && i < 12; i++) begin
            pc = 32'(4 * i);
            n_chk++;
            if (acc_q[i].pc !== pc || acc_q[i].data !== (pc ^ KEY))
                $display("FAIL bp_seq_%0d: got pc=%h d=%h exp pc=%h d=%h", i, acc_q[i].pc, acc_q[i].data, pc, pc ^ KEY);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        bit ok;
        logic [31:0] pc;
        do_reset(1'b1, 3);
        step();
        step();
        gnt_en = 1'b0;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0100;
        step();
        bus.branch_taken = 1'b0;
        gnt_en = 1'b1;
        n_chk++; if (bus.imem_addr !== 32'h100 || bus.imem_req !== 1'b1) $display("FAIL redir_addr: got req=%b addr=%h exp req=1 addr=100", bus.imem_req, bus.imem_addr); else n_pass++;
        n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL redir_flush: got %b exp 0", bus.instr_valid); else n_pass++;
        wait_acc(3, 30, ok);
        n_chk++; if (!ok) $display("FAIL redir_timeout: got %0d accepted exp 3", acc_q.size()); else n_pass++;
        for (int i = 0; i < acc_q.size() && i < 3; i++) begin
            pc = 32'h100 + 32'(4 * i);
            n_chk++;
            if (acc_q[i].pc !== pc || acc_q[i].data !== (pc ^ KEY))
                $display("FAIL redir_seq_%0d: got pc=%h d=%h exp pc=%h d=%h", i, acc_q[i].pc, acc_q[i].data, pc, pc ^ KEY);
            else n_pass++;
        end
    endtask

    task automatic test_collision();
        bit ok;
        logic [31:0] pc;
        do_reset(1'b1, 1);
        repeat (5) step();
        n_chk++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hC || bus.imem_req !== 1'b1)
            $display("FAIL coll_pre: got v=%b pc=%h req=%b exp v=1 pc=c req=1", bus.instr_valid, bus.instr_pc, bus.imem_req);
        else n_pass++;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0203;
        step();
        bus.branch_taken = 1'b0;
        acc_q.delete();
        n_chk++; if (bus.imem_addr !== 32'h200) $display("FAIL coll_addr: got %h exp 200", bus.imem_addr); else n_pass++;
        n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL coll_t1_valid: got %b exp 0", bus.instr_valid); else n_pass++;
        step();
        n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL coll_t2_valid: got %b exp 0", bus.instr_valid); else n_pass++;
        step();
        n_chk++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200 || bus.instr !== (32'h200 ^ KEY))
            $display("FAIL coll_t3: got v=%b pc=%h d=%h exp v=1 pc=200 d=%h", bus.instr_valid, bus.instr_pc, bus.instr, 32'h200 ^ KEY);
        else n_pass++;
        wait_acc(4, 20, ok);
        n_chk++; if (!ok) $display("FAIL coll_timeout: got %0d accepted exp 4", acc_q.size()); else n_pass++;
        for (int i = 0; i < acc_q.size() && i < 4; i++) begin
            pc = 32'h200 + 32'(4 * i);
            n_chk++;
            if (acc_q[i].pc !== pc || acc_q[i].data !== (pc ^ KEY))
                $display("FAIL coll_seq_%0d: got pc=%h d=%h exp pc=%h d=%h", i, acc_q[i].pc, acc_q[i].data, pc, pc ^ KEY);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        logic [31:0] pc;
        do_reset(1'b0, 4);
        repeat (6) step();
        n_chk++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0)
            $display("FAIL mid_pre: got req=%b v=%b pc=%h exp req=0 v=1 pc=0", bus.imem_req, bus.instr_valid, bus.instr_pc);
        else n_pass++;
        reset = 1'b1;
        step();
        n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL mid_valid: got %b exp 0", bus.instr_valid); else n_pass++;
        n_chk++; if (bus.imem_addr !== 32'h0) $display("FAIL mid_addr: got %h exp 0", bus.imem_addr); else n_pass++;
        n_chk++; if (bus.imem_req !== 1'b0) $display("FAIL mid_req: got %b exp 0", bus.imem_req); else n_pass++;
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        lat = 1;
        acc_q.delete();
        step();
        n_chk++; if (bus.instr_valid !== 1'b0) $display("FAIL mid_c1_valid: got %b exp 0", bus.instr_valid); else n_pass++;
        wait_acc(3, 20, ok);
        n_chk++; if (!ok) $display("FAIL mid_timeout: got %0d accepted exp 3", acc_q.size()); else n_pass++;
        for (int i = 0; i < acc_q.size() && i < 3; i++) begin
            pc = 32'(4 * i);
            n_chk++;
            if (acc_q[i].pc !== pc || acc_q[i].data !== (pc ^ KEY))
                $display("FAIL mid_seq_%0d: got pc=%h d=%h exp pc=%h d=%h", i, acc_q[i].pc, acc_q[i].data, pc, pc ^ KEY);
            else n_pass++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        lat    = 1;
        gnt_en = 1'b0;
        reset  = 1'b1;
        bus.imem_gnt      = 1'b0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = 32'h0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.instr_ready   = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_collision();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
